dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Port: clk_i  in  1  CPU clock; all state updates on its rising edge.
REQ-004 Port: rst_i  in  1  asynchronous, active-high reset.
REQ-005 Port: req_i  in  1  CPU data-access request.
REQ-006 Port: we_i  in  1  1 = store, 0 = load.
REQ-007 Port: adr_i  in  ADDR_W  byte address.
REQ-008 Port: wd_i  in  32  store data, right-aligned.
REQ-009 Port: size_i  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal.
REQ-010 Port: sext_i  in  1  sign-extend sub-word loads when 1; zero-extend when 0.
REQ-011 Port: ready_o  out  1  request accepted on any edge where req_i && ready_o.
REQ-012 Port: rvalid_o  out  1  one-cycle response strobe.
REQ-013 Port: rdata_o  out  32  load result, valid with rvalid_o.
REQ-014 Port: err_o  out  1  misaligned or illegal access, valid with rvalid_o.
REQ-015 Port: ram_adr_o  out  ADDR_W-2  word address to the synchronous RAM.
REQ-016 Port: ram_we_o  out  1  RAM write enable.
REQ-017 Port: ram_wd_o  out  32  RAM write word.
REQ-018 Port: ram_rd_i  in  32  RAM read word, valid one cycle after the address is presented.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, WAIT, MERGE, RESP.
REQ-020 ready_o SHALL be 1 only in IDLE, decoded combinationally from state.
REQ-021 At acceptance the block SHALL latch we_i, adr_i, wd_i, size_i and sext_i; later input changes SHALL have no effect on the transaction.
REQ-022 Misaligned or illegal requests SHALL go IDLE->RESP with err_o=1 and no RAM access. Misaligned means half with adr[0]=1, word with adr[1:0]!=0, or size 11.
REQ-023 For a legal request, IDLE SHALL go to ACCESS, and ram_adr_o SHALL be adr[ADDR_W-1:2] from ACCESS through MERGE.
REQ-024 Word store: in ACCESS, ram_we_o=1 and ram_wd_o=wd; then ACCESS->RESP.
REQ-025 Load and sub-word store: ACCESS->WAIT; in WAIT, ram_rd_i SHALL be captured.
REQ-026 Load: WAIT->RESP; rdata_o SHALL be the byte selected by adr[1:0] or the half selected by adr[1], extended per sext, or the full word.
REQ-027 Sub-word store: WAIT->MERGE; in MERGE, ram_we_o=1 and ram_wd_o = captured word with only the addressed byte/half lanes replaced by wd's low bits; then MERGE->RESP.
REQ-028 RESP SHALL assert rvalid_o for exactly one cycle and then go to IDLE; rdata_o=0 on stores and errors.
REQ-029 Latency from acceptance edge to the rvalid_o cycle SHALL be: error 1, word store 2, load 3, sub-word store 4; no back-to-back acceptance is possible, so the minimum accept spacing is latency+1.
REQ-030 ram_we_o SHALL be 0 in every state other than the two write cycles above, and for exactly one cycle per store.
REQ-031 rdata_o and err_o SHALL hold their values until the next RESP.

Reset
REQ-032 rst_i SHALL asynchronously force state to IDLE and rvalid_o, rdata_o, err_o, ram_we_o, ram_adr_o and ram_wd_o to 0.
REQ-033 Reset mid-transaction SHALL abort it with no response; if reset is asserted during a write cycle, ram_we_o SHALL drop immediately.
REQ-034 ready_o SHALL be 1 in the first cycle after reset release.

Structure
REQ-035 Shared package dbus_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enumeration.
REQ-036 Lane extract/merge logic SHALL be a combinational sub-module dbus_lane_unit, instantiated once.

Verification
REQ-037 Word store then load: store adr 0x0010, wd 0xDEADBEEF -> RAM write at word 0x0004 in cycle 1, rvalid_o at cycle 2; load adr 0x0010 -> rdata_o=0xDEADBEEF at cycle 3.
REQ-038 Byte store merge: RAM word 4 = 0x11223344; store byte adr 0x0012, wd 0x000000AB -> one write of 0x11AB3344, rvalid_o at cycle 4.
REQ-039 Signed/unsigned loads: RAM word 0 = 0x80FF7F01; byte load adr 0x0001 sext=1 -> 0x0000007F; half load adr 0x0002 sext=1 -> 0xFFFF80FF; same half load with sext=0 -> 0x000080FF.
REQ-040 Misaligned access: word load adr 0x0002 -> err_o=1 and rvalid_o at cycle 1, with ram_we_o never asserted.
REQ-041 Reset in MERGE: assert rst_i in the MERGE cycle -> ram_we_o=0 immediately, RAM word unchanged, no rvalid_o, ready_o=1 after release.
REQ-042 Input hold: change adr_i and wd_i in the cycle after acceptance -> the transaction uses the latched values, and ready_o stays 0 until RESP completes.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared definitions for the CPU data-bus responder: access-size encodings,
// FSM state enumeration and the alignment check used at request acceptance.
package dbus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        MERGE,
        RESP
    } state_t;

    // Size 11 is never legal, so it is reported as misaligned too.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dbus_lane_unit.sv
// Combinational lane logic: extracts/extends a byte or half from a RAM word
// for loads, and merges store data into the addressed lanes for sub-word stores.
module dbus_lane_unit
    import dbus_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wd,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sext,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte  = word[{off, 3'b000} +: 8];
        sel_half  = off[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sext & sel_byte[7]}}, sel_byte};
                merged[{off, 3'b000} +: 8] = wd[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sext & sel_half[15]}}, sel_half};
                if (off[1]) begin
                    merged[31:16] = wd[15:0];
                end else begin
                    merged[15:0] = wd[15:0];
                end
            end
            default: begin
                load_data = word;
                merged    = wd;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: accepts one access at a time, drives a synchronous
// word RAM (read-modify-write for sub-word stores) and returns a one-cycle response.
module dmem_responder
    import dbus_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [31:0]       wd_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic [ADDR_W-3:0] ram_adr_o,
    output logic              ram_we_o,
    output logic [31:0]       ram_wd_o,
    input  logic [31:0]       ram_rd_i
);

    state_t state, state_next;

    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [31:0]       wd_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [31:0]       rd_q;

    logic [31:0] lane_word;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        accept;
    logic        resp_enter;

    assign accept     = (state == IDLE) && req_i;
    assign resp_enter = (state_next == RESP) && (state != RESP);
    assign ready_o    = (state == IDLE);
    assign rvalid_o   = (state == RESP);
    assign ram_adr_o  = adr_q[ADDR_W-1:2];

    // Loads extract straight from the RAM read port in WAIT; merges use the captured word.
    assign lane_word = (state == MERGE) ? rd_q : ram_rd_i;

    dbus_lane_unit u_lane (
        .word      (lane_word),
        .wd        (wd_q),
        .size      (size_q),
        .off       (adr_q[1:0]),
        .sext      (sext_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wd_q    <= '0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            rd_q    <= '0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q   <= we_i;
                adr_q  <= adr_i;
                wd_q   <= wd_i;
                size_q <= size_i;
                sext_q <= sext_i;
            end
            if (state == WAIT) begin
                rd_q <= ram_rd_i;
            end
            // Response fields change only on entry to RESP so they hold between responses.
            if (resp_enter) begin
                err_o   <= (state == IDLE);
                rdata_o <= (state == WAIT && !we_q) ? load_data : 32'h0;
            end
        end
    end

    // Write enable is decoded from state so an async reset drops it immediately.
    always_comb begin
        state_next = state;
        ram_we_o   = 1'b0;
        ram_wd_o   = 32'h0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    state_next = is_misaligned(size_i, adr_i[1:0]) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (we_q && size_q == SZ_WORD) begin
                    ram_we_o   = 1'b1;
                    ram_wd_o   = wd_q;
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = we_q ? MERGE : RESP;
            end
            MERGE: begin
                ram_we_o   = 1'b1;
                ram_wd_o   = merged;
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed accesses against a small
// synchronous RAM model, with response and RAM-write monitors.
module tb_dmem_responder;

    localparam int ADDR_W = 16;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } resp_t;

    typedef struct {
        logic [ADDR_W-3:0] adr;
        logic [31:0]       data;
    } wr_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] adr_i;
    logic [31:0]       wd_i;
    logic [1:0]        size_i;
    logic              sext_i;
    logic              ready_o;
    logic              rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic [ADDR_W-3:0] ram_adr_o;
    logic              ram_we_o;
    logic [31:0]       ram_wd_o;
    logic [31:0]       ram_rd_i;

    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_adr = '0;
    logic [31:0] pre_data = '0;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_fail = 0;

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .adr_i     (adr_i),
        .wd_i      (wd_i),
        .size_i    (size_i),
        .sext_i    (sext_i),
        .ready_o   (ready_o),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .ram_adr_o (ram_adr_o),
        .ram_we_o  (ram_we_o),
        .ram_wd_o  (ram_wd_o),
        .ram_rd_i  (ram_rd_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Synchronous RAM: read data appears one cycle after the address.
    always @(posedge clk_i) begin
        if (pre_we) begin
            mem[pre_adr] <= pre_data;
        end else if (ram_we_o) begin
            mem[ram_adr_o[5:0]] <= ram_wd_o;
        end
        ram_rd_i <= mem[ram_adr_o[5:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && rvalid_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected rvalid", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                checkOutput("rdata", rdata_o, e.rdata);
                checkOutput("err", {31'd0, err_o}, {31'd0, e.err});
                checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    always @(negedge clk_i) begin
        if (ram_we_o) begin
            if (wr_q.size() == 0) begin
                checkOutput("unexpected ram write", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                checkOutput("ram_adr", 32'(ram_adr_o), 32'(w.adr));
                checkOutput("ram_wd", ram_wd_o, w.data);
            end
        end
    end

    task automatic preload(input logic [5:0] adr, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_adr  = adr;
        pre_data = data;
        @(negedge clk_i);
        pre_we = 1'b0;
    endtask

    // Issues one request from a negedge, scrambles the inputs right after acceptance
    // and returns at the negedge following the response.
    task automatic applyStimulus(input logic we, input logic [15:0] adr, input logic [31:0] wd,
                                 input logic [1:0] size, input logic sext,
                                 input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                                 input logic has_wr, input logic [13:0] wr_adr, input logic [31:0] wr_data);
        resp_t e;
        wr_t   w;
        bit    seen;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.acc   = cyc;
        exp_q.push_back(e);
        if (has_wr) begin
            w.adr  = wr_adr;
            w.data = wr_data;
            wr_q.push_back(w);
        end
        req_i  = 1'b1;
        we_i   = we;
        adr_i  = adr;
        wd_i   = wd;
        size_i = size;
        sext_i = sext;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i  = 1'b0;
        we_i   = ~we;
        adr_i  = adr ^ 16'h00FC;
        wd_i   = ~wd;
        size_i = ~size;
        sext_i = ~sext;
        seen   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rvalid_o) begin
                seen = 1'b1;
                break;
            end
            checkOutput("ready busy", {31'd0, ready_o}, 32'd0);
            @(negedge clk_i);
        end
        if (!seen) begin
            checkOutput("rvalid timeout", 32'd0, 32'd1);
        end
        @(negedge clk_i);
        checkOutput("ready after resp", {31'd0, ready_o}, 32'd1);
        checkOutput("rdata hold", rdata_o, exp_rdata);
        checkOutput("err hold", {31'd0, err_o}, {31'd0, exp_err});
    endtask

    initial begin
        wr_t w;
        rst_i  = 1'b1;
        req_i  = 1'b0;
        we_i   = 1'b0;
        adr_i  = '0;
        wd_i   = '0;
        size_i = 2'b00;
        sext_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset rvalid", {31'd0, rvalid_o}, 32'd0);
        checkOutput("reset rdata", rdata_o, 32'd0);
        checkOutput("reset err", {31'd0, err_o}, 32'd0);
        checkOutput("reset ram_we", {31'd0, ram_we_o}, 32'd0);
        checkOutput("reset ram_adr", 32'(ram_adr_o), 32'd0);
        checkOutput("reset ram_wd", ram_wd_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("ready after reset", {31'd0, ready_o}, 32'd1);

        $display("[TB] word store then load");
        applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 2, 1'b1, 14'h0004, 32'hDEADBEEF);
        applyStimulus(1'b0, 16'h0010, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 3, 1'b0, 14'h0, 32'h0);

        $display("[TB] byte store merge");
        preload(6'd4, 32'h11223344);
        applyStimulus(1'b1, 16'h0012, 32'h000000AB, 2'b00, 1'b0, 32'h0, 1'b0, 4, 1'b1, 14'h0004, 32'h11AB3344);
        applyStimulus(1'b0, 16'h0010, 32'h0, 2'b10, 1'b0, 32'h11AB3344, 1'b0, 3, 1'b0, 14'h0, 32'h0);

        $display("[TB] signed and unsigned loads");
        preload(6'd0, 32'h80FF7F01);
        applyStimulus(1'b0, 16'h0001, 32'h0, 2'b00, 1'b1, 32'h0000007F, 1'b0, 3, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b0, 16'h0002, 32'h0, 2'b01, 1'b1, 32'hFFFF80FF, 1'b0, 3, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b0, 16'h0002, 32'h0, 2'b01, 1'b0, 32'h000080FF, 1'b0, 3, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b0, 16'h0003, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0, 3, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b0, 16'h0003, 32'h0, 2'b00, 1'b0, 32'h00000080, 1'b0, 3, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b0, 16'h0000, 32'h0, 2'b01, 1'b1, 32'h00007F01, 1'b0, 3, 1'b0, 14'h0, 32'h0);

        $display("[TB] half store merge");
        applyStimulus(1'b1, 16'h0002, 32'hFFFF1234, 2'b01, 1'b0, 32'h0, 1'b0, 4, 1'b1, 14'h0000, 32'h12347F01);
        applyStimulus(1'b0, 16'h0000, 32'h0, 2'b10, 1'b0, 32'h12347F01, 1'b0, 3, 1'b0, 14'h0, 32'h0);

        $display("[TB] misaligned and illegal accesses");
        applyStimulus(1'b0, 16'h0002, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b0, 16'h0001, 32'h0, 2'b01, 1'b1, 32'h0, 1'b1, 1, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b0, 16'h0000, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b1, 16'h0011, 32'h55555555, 2'b10, 1'b0, 32'h0, 1'b1, 1, 1'b0, 14'h0, 32'h0);
        applyStimulus(1'b0, 16'h0000, 32'h0, 2'b10, 1'b0, 32'h12347F01, 1'b0, 3, 1'b0, 14'h0, 32'h0);

        $display("[TB] reset during merge write");
        preload(6'd5, 32'hAABBCCDD);
        w.adr  = 14'h0005;
        w.data = 32'hAABB55DD;
        wr_q.push_back(w);
        req_i  = 1'b1;
        we_i   = 1'b1;
        adr_i  = 16'h0015;
        wd_i   = 32'h00000055;
        size_i = 2'b00;
        sext_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("merge we before reset", {31'd0, ram_we_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("merge we under reset", {31'd0, ram_we_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("ready after abort", {31'd0, ready_o}, 32'd1);
        checkOutput("rdata after abort", rdata_o, 32'd0);
        repeat (4) @(negedge clk_i);
        checkOutput("ram word after abort", mem[5], 32'hAABBCCDD);
        applyStimulus(1'b0, 16'h0014, 32'h0, 2'b10, 1'b0, 32'hAABBCCDD, 1'b0, 3, 1'b0, 14'h0, 32'h0);

        repeat (2) @(negedge clk_i);
        checkOutput("pending responses", 32'(exp_q.size()), 32'd0);
        checkOutput("pending writes", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
